leon3s_signature: RTL and testbench

- Output-side counterpart to the input random stimulus generator in the out-of-context wrappers.
- Compacts a wide core output bus into a multiple-input signature register (MISR) over a fixed window of enabled cycles.
- Snapshots each finished signature and shifts it out serially on one pin, so every core output stays observable and synthesis cannot prune output logic.
- Sits in the OOC top level between the core outputs (e.g. ahbo/irqo/dbgo concatenated) and a single top-level output pin.

---
 rtl/leon3s_signature_pkg.sv | 34 +++
 rtl/leon3s_signature_if.sv | 14 +
 rtl/leon3s_signature_misr_core.sv | 37 +++
 rtl/leon3s_signature.sv | 100 ++++++++++
 tb/tb_leon3s_signature.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/leon3s_signature_pkg.sv
// Shared constants, shifter state encoding and the bus-folding helper for the
// output signature compactor.
package leon3s_signature_pkg;

   localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
   localparam logic [31:0] DEF_SEED = 32'h00000001;

   // Upper bounds for the fold helper; callers zero-extend into these.
   localparam int FOLD_MAX_W = 256;
   localparam int FOLD_MAX_S = 64;

   typedef enum logic [0:0] {
      SH_IDLE = 1'b0,
      SH_BUSY = 1'b1
   } sh_state_e;

   // XOR successive sig_width-bit chunks of data together. Bits above the real
   // bus width must already be zero, which gives the zero-padded last chunk.
   function automatic logic [FOLD_MAX_S-1:0] fold_bus(input logic [FOLD_MAX_W-1:0] data,
                                                      input int sig_width);
      logic [FOLD_MAX_S-1:0] f;
      logic [FOLD_MAX_S-1:0] mask;
      logic [FOLD_MAX_W-1:0] rest;
      mask = ~({FOLD_MAX_S{1'b1}} << sig_width);
      rest = data;
      f    = '0;
      for (int c = 0; c < FOLD_MAX_W / 2; c++) begin
         f    = f ^ (rest[FOLD_MAX_S-1:0] & mask);
         rest = rest >> sig_width;
      end
      return f;
   endfunction

endpackage

// File: rtl/leon3s_signature_if.sv
// Observed-bus / serial-signature port bundle between the core outputs and the
// signature compactor.
interface leon3s_signature_if #(
   parameter int WIDTH = 32
);
   logic             en;
   logic [WIDTH-1:0] data_in;
   logic             sig_out;
   logic             sig_valid;
   logic             overrun;

   modport master (output en, data_in, input sig_out, sig_valid, overrun);
   modport slave  (input en, data_in, output sig_out, sig_valid, overrun);
endinterface

// File: rtl/leon3s_signature_misr_core.sv
// MISR register: steps on enable, reloads the seed instead of stepping when a
// window closes.
module leon3s_signature_misr_core
   import leon3s_signature_pkg::*;
#(
   parameter int          SIG_WIDTH = 32,
   parameter logic [31:0] POLY      = DEF_POLY,
   parameter logic [31:0] SEED      = DEF_SEED
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 step,
   input  logic                 reseed,
   input  logic [SIG_WIDTH-1:0] fold,
   output logic [SIG_WIDTH-1:0] misr_next,
   output logic [SIG_WIDTH-1:0] misr_cur
);

   localparam logic [SIG_WIDTH-1:0] POLY_W = SIG_WIDTH'(POLY);
   localparam logic [SIG_WIDTH-1:0] SEED_W = SIG_WIDTH'(SEED);

   logic [SIG_WIDTH-1:0] misr_d, misr_q;

   always_comb begin
      misr_next = {misr_q[SIG_WIDTH-2:0], 1'b0} ^ (misr_q[SIG_WIDTH-1] ? POLY_W : '0) ^ fold;
      misr_d    = misr_q;
      if (step) misr_d = reseed ? SEED_W : misr_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) misr_q <= SEED_W;
      else        misr_q <= misr_d;
   end

   assign misr_cur = misr_q;

endmodule

// File: rtl/leon3s_signature.sv
// Compacts a wide observed bus into a MISR signature per window of enabled
// cycles and shifts each finished signature out MSB first on one pin.
module leon3s_signature
   import leon3s_signature_pkg::*;
#(
   parameter int          WIDTH     = 32,
   parameter int          SIG_WIDTH = 32,
   parameter logic [31:0] POLY      = DEF_POLY,
   parameter logic [31:0] SEED      = DEF_SEED,
   parameter int          WINDOW    = 256
) (
   input logic               clk,
   input logic               reset,
   leon3s_signature_if.slave bus
);

   localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int BC_W  = $clog2(SIG_WIDTH);

   logic [FOLD_MAX_W-1:0] data_ext;
   logic [FOLD_MAX_S-1:0] fold_all;
   logic [SIG_WIDTH-1:0]  fold, misr_next, misr_cur;
   logic                  snap, last_bit;
   logic                  unused_bits;

   logic [CNT_W-1:0]     win_d, win_q;
   sh_state_e            state_d, state_q;
   logic [SIG_WIDTH-1:0] shreg_d, shreg_q;
   logic [BC_W-1:0]      bcnt_d, bcnt_q;
   logic                 ovr_d, ovr_q;

   assign data_ext    = FOLD_MAX_W'(bus.data_in);
   assign fold_all    = fold_bus(data_ext, SIG_WIDTH);
   assign fold        = fold_all[SIG_WIDTH-1:0];
   assign unused_bits = ^{misr_cur, fold_all};

   leon3s_signature_misr_core #(
      .SIG_WIDTH(SIG_WIDTH),
      .POLY     (POLY),
      .SEED     (SEED)
   ) u_misr (
      .clk      (clk),
      .reset    (reset),
      .step     (bus.en),
      .reseed   (snap),
      .fold     (fold),
      .misr_next(misr_next),
      .misr_cur (misr_cur)
   );

   always_comb begin
      snap  = bus.en && (win_q == CNT_W'(WINDOW - 1));
      win_d = win_q;
      if (bus.en) win_d = snap ? '0 : win_q + CNT_W'(1);
   end

   // The shifter drains to all-zero after SIG_WIDTH shifts, so sig_out is
   // simply the register MSB and reads 0 whenever idle.
   always_comb begin
      last_bit = (bcnt_q == BC_W'(SIG_WIDTH - 1));
      state_d  = state_q;
      shreg_d  = shreg_q;
      bcnt_d   = bcnt_q;
      ovr_d    = ovr_q;
      if (state_q == SH_BUSY) begin
         shreg_d = {shreg_q[SIG_WIDTH-2:0], 1'b0};
         bcnt_d  = bcnt_q + BC_W'(1);
         if (last_bit) state_d = SH_IDLE;
      end
      // A new snapshot always wins; it only counts as lost data if the old
      // signature had bits left to present.
      if (snap) begin
         shreg_d = misr_next;
         bcnt_d  = '0;
         state_d = SH_BUSY;
         if (state_q == SH_BUSY && !last_bit) ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         win_q   <= '0;
         state_q <= SH_IDLE;
         shreg_q <= '0;
         bcnt_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         win_q   <= win_d;
         state_q <= state_d;
         shreg_q <= shreg_d;
         bcnt_q  <= bcnt_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.sig_out   = shreg_q[SIG_WIDTH-1];
   assign bus.sig_valid = (state_q == SH_BUSY);
   assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_leon3s_signature.sv
// Bench for the signature compactor: four configurations, a shared serial
// monitor with an expected-signature queue, plus directed corner sequences.
module tb_leon3s_signature;

   typedef struct packed {
      logic [3:0][31:0] d;
      logic [31:0]      sig;
   } vec_t;

   typedef struct {
      int          dut;
      logic [31:0] sig;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [3:0] so_v, sv_v, ov_v;
   logic [3:0] mon_en;
   int         nvec = 0;
   int         nmis = 0;
   exp_t       sb[$];

   leon3s_signature_if #(.WIDTH(32)) ia ();
   leon3s_signature_if #(.WIDTH(32)) ib ();
   leon3s_signature_if #(.WIDTH(64)) ic ();
   leon3s_signature_if #(.WIDTH(32)) id ();

   leon3s_signature #(.WIDTH(32), .SIG_WIDTH(32), .POLY(32'h04C11DB7), .SEED(32'h00000001), .WINDOW(4))
      u_a (.clk(clk), .reset(reset), .bus(ia));
   leon3s_signature #(.WIDTH(32), .SIG_WIDTH(32), .POLY(32'h04C11DB7), .SEED(32'h80000000), .WINDOW(1))
      u_b (.clk(clk), .reset(reset), .bus(ib));
   leon3s_signature #(.WIDTH(64), .SIG_WIDTH(32), .POLY(32'h04C11DB7), .SEED(32'h00000001), .WINDOW(1))
      u_c (.clk(clk), .reset(reset), .bus(ic));
   leon3s_signature #(.WIDTH(32), .SIG_WIDTH(32), .POLY(32'h04C11DB7), .SEED(32'h00000001), .WINDOW(32))
      u_d (.clk(clk), .reset(reset), .bus(id));

   assign so_v = {id.sig_out,   ic.sig_out,   ib.sig_out,   ia.sig_out};
   assign sv_v = {id.sig_valid, ic.sig_valid, ib.sig_valid, ia.sig_valid};
   assign ov_v = {id.overrun,   ic.overrun,   ib.overrun,   ia.overrun};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      nvec++;
      if (act !== want) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   task automatic push(input int k, input logic [31:0] s);
      sb.push_back('{dut: k, sig: s});
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         cyc();
         n++;
      end
      if (sb.size() != 0) begin
         nvec++;
         nmis++;
         $display("FAIL sb_timeout: %0d signatures still pending", sb.size());
         sb.delete();
      end
      cyc();
   endtask

   // Serial monitor: reassembles each 32-bit frame and checks it against the queue.
   initial begin
      logic [31:0] acc [4];
      int          nb [4];
      exp_t        e;
      for (int k = 0; k < 4; k++) begin
         acc[k] = '0;
         nb[k]  = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            if (reset !== 1'b1 || !mon_en[k]) begin
               nb[k] = 0;
            end else if (sv_v[k]) begin
               acc[k] = {acc[k][30:0], so_v[k]};
               nb[k]++;
               if (nb[k] == 32) begin
                  nb[k] = 0;
                  if (sb.size() == 0) begin
                     nvec++;
                     nmis++;
                     $display("FAIL sb_unexpected: dut %0d shifted %h with nothing expected", k, acc[k]);
                  end else begin
                     e = sb.pop_front();
                     chk("sb_dut", 32'(k), 32'(e.dut));
                     chk("signature", acc[k], e.sig);
                  end
               end
            end else begin
               if (nb[k] != 0) begin
                  nvec++;
                  nmis++;
                  $display("FAIL sig_short: dut %0d frame ended after %0d bits, expected 32", k, nb[k]);
                  nb[k] = 0;
               end
               chk("idle_sig_out", 32'(so_v[k]), 32'h0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [6];
      logic [63:0] cd [3];
      logic [31:0] cs [3];
      logic [31:0] acc;
      int          n;

      tbl[0] = '{d: {32'h0, 32'h0, 32'h0, 32'h0},                  sig: 32'h00000010};
      tbl[1] = '{d: {32'h1, 32'h0, 32'h0, 32'h0},                  sig: 32'h00000018};
      tbl[2] = '{d: {32'h0, 32'h0, 32'h0, 32'h1},                  sig: 32'h00000011};
      tbl[3] = '{d: {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF},           sig: 32'hFFFFFFEF};
      tbl[4] = '{d: {32'h80000000, 32'h0, 32'h0, 32'h0},           sig: 32'h130476CC};
      tbl[5] = '{d: {32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'h0},    sig: 32'h5740328C};
      cd[0] = 64'hFFFF0000_0000FFFF;  cs[0] = 32'hFFFFFFFD;
      cd[1] = 64'h00000001_00000000;  cs[1] = 32'h00000003;
      cd[2] = 64'h12345678_12345678;  cs[2] = 32'h00000002;

      reset  = 1'b0;
      mon_en = 4'b1111;
      ia.en = 1'b0; ia.data_in = '0;
      ib.en = 1'b0; ib.data_in = '0;
      ic.en = 1'b0; ic.data_in = '0;
      id.en = 1'b0; id.data_in = '0;
      repeat (3) cyc();
      for (int k = 0; k < 4; k++) begin
         chk("rst_sig_valid", 32'(sv_v[k]), 32'h0);
         chk("rst_sig_out",   32'(so_v[k]), 32'h0);
         chk("rst_overrun",   32'(ov_v[k]), 32'h0);
      end
      reset = 1'b1;

      // Zero-data window: latency and exact frame length.
      push(0, 32'h00000010);
      for (int i = 0; i < 4; i++) begin
         ia.en = 1'b1; ia.data_in = '0;
         cyc();
         if (i < 3) chk("pre_snap_valid", 32'(sv_v[0]), 32'h0);
      end
      ia.en = 1'b0;
      chk("first_bit_valid", 32'(sv_v[0]), 32'h1);
      n = 0;
      while (sv_v[0] && n < 40) begin
         n++;
         cyc();
      end
      chk("valid_len", 32'(n), 32'd32);

      // Table windows; odd entries get en=0 gaps with junk data between enabled cycles.
      for (int v = 0; v < 6; v++) begin
         push(0, tbl[v].sig);
         for (int i = 0; i < 4; i++) begin
            ia.en = 1'b1; ia.data_in = tbl[v].d[3-i];
            cyc();
            if (v % 2 == 1) begin
               ia.en = 1'b0; ia.data_in = $urandom;
               repeat (v) cyc();
            end
         end
         ia.en = 1'b0; ia.data_in = $urandom;
         wait_idle();
      end

      // Feedback from a seed with only the MSB set, and reseed on WINDOW=1.
      push(1, 32'h04C11DB7);
      ib.en = 1'b1; ib.data_in = '0;
      cyc();
      ib.en = 1'b0; ib.data_in = $urandom;
      chk("b_first_bit_valid", 32'(sv_v[1]), 32'h1);
      wait_idle();
      push(1, 32'h04C11DB6);
      ib.en = 1'b1; ib.data_in = 32'h1;
      cyc();
      ib.en = 1'b0;
      wait_idle();

      // 64-bit bus folded into 32.
      for (int v = 0; v < 3; v++) begin
         push(2, cs[v]);
         ic.en = 1'b1; ic.data_in = cd[v];
         cyc();
         ic.en = 1'b0; ic.data_in = '0;
         wait_idle();
      end

      // Back-to-back snapshots landing exactly on the final-bit edge.
      push(3, 32'h04C11DB7);
      push(3, 32'h04C11DB7);
      for (int i = 0; i < 64; i++) begin
         id.en = 1'b1; id.data_in = '0;
         cyc();
         if (i >= 32) chk("d_continuous_valid", 32'(sv_v[3]), 32'h1);
      end
      id.en = 1'b0;
      wait_idle();
      chk("d_no_overrun", 32'(ov_v[3]), 32'h0);

      // Overrun: second snapshot while bit 4 of the first is on the pin.
      mon_en[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ia.en = 1'b1; ia.data_in = '0;
         cyc();
         if (i >= 3) chk("ovr_valid_cont", 32'(sv_v[0]), 32'h1);
         if (i == 6) chk("ovr_before", 32'(ov_v[0]), 32'h0);
      end
      chk("ovr_set", 32'(ov_v[0]), 32'h1);
      ia.en = 1'b0;
      acc = '0;
      for (int b = 0; b < 32; b++) begin
         chk("ovr_frame_valid", 32'(sv_v[0]), 32'h1);
         acc = {acc[30:0], so_v[0]};
         cyc();
      end
      chk("ovr_restarted_sig", acc, 32'h00000010);
      chk("ovr_frame_end",     32'(sv_v[0]), 32'h0);
      chk("ovr_sticky",        32'(ov_v[0]), 32'h1);

      // Reset while bit 10 of a frame is on the pin.
      for (int i = 0; i < 4; i++) begin
         ia.en = 1'b1; ia.data_in = '0;
         cyc();
      end
      ia.en = 1'b0;
      repeat (10) cyc();
      chk("pre_rst_valid", 32'(sv_v[0]), 32'h1);
      reset = 1'b0;
      cyc();
      chk("mid_rst_valid",   32'(sv_v[0]), 32'h0);
      chk("mid_rst_sig_out", 32'(so_v[0]), 32'h0);
      chk("mid_rst_overrun", 32'(ov_v[0]), 32'h0);
      reset     = 1'b1;
      mon_en[0] = 1'b1;
      push(0, 32'h00000010);
      for (int i = 0; i < 4; i++) begin
         ia.en = 1'b1; ia.data_in = '0;
         cyc();
      end
      ia.en = 1'b0;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
